// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one 64-bit memory port between the I-fetch and D requesters
// One transaction in flight at a time; a response timeout forces an error completion.
module riscv_mem_arbiter #(
   parameter int ARB_MODE = 0,
   parameter int TIMEOUT  = 16,
   parameter int CNT_W    = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [29:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic        d_wen,
   input  logic [29:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic [63:0] d_rdata,
   output logic        d_ack,
   output logic        err,
   output logic        mem_req,
   output logic        mem_wen,
   output logic [28:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   localparam logic             RR       = (ARB_MODE != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_q, owner_d;           // 1 = D side owns the transaction
   logic             last_grant_q, last_grant_d; // 1 = D was granted last
   logic             wen_q, wen_d;
   logic             sel_hi_q, sel_hi_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_wen_q, mem_wen_d;
   logic [28:0]      mem_addr_q, mem_addr_d;
   logic [63:0]      mem_wdata_q, mem_wdata_d;
   logic             i_ack_q, i_ack_d;
   logic             d_ack_q, d_ack_d;
   logic             err_q, err_d;
   logic [31:0]      i_rdata_q, i_rdata_d;
   logic [63:0]      d_rdata_q, d_rdata_d;
   logic             pick_d;
   logic             timeout_hit;
   logic             unused_d_addr_bit;

   assign unused_d_addr_bit = d_addr[0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      wen_d        = wen_q;
      sel_hi_d     = sel_hi_q;
      mem_req_d    = mem_req_q;
      mem_wen_d    = mem_wen_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      err_d        = 1'b0;
      i_rdata_d    = '0;
      d_rdata_d    = '0;
      pick_d       = d_req & (~i_req | ~RR | ~last_grant_q);
      timeout_hit  = (cnt_q == CNT_LAST);

      case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               state_d      = S_REQ;
               cnt_d        = '0;
               owner_d      = pick_d;
               last_grant_d = pick_d;
               wen_d        = pick_d & d_wen;
               sel_hi_d     = i_addr[0];
               mem_req_d    = 1'b1;
               mem_wen_d    = pick_d & d_wen;
               mem_addr_d   = pick_d ? d_addr[29:1] : i_addr[29:1];
               mem_wdata_d  = pick_d ? d_wdata : 64'd0;
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout_hit || mem_gnt) begin
               mem_req_d   = 1'b0;
               mem_wen_d   = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
            end
            // A late grant in the last allowed cycle still loses to the timeout.
            if (timeout_hit) begin
               state_d = S_RESP;
               i_ack_d = ~owner_q;
               d_ack_d = owner_q;
               err_d   = 1'b1;
            end else if (mem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_rvalid) begin
               state_d = S_RESP;
               if (owner_q) begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = wen_q ? 64'd0 : mem_rdata;
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
               end
            end else if (timeout_hit) begin
               state_d = S_RESP;
               i_ack_d = ~owner_q;
               d_ack_d = owner_q;
               err_d   = 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b0;
         wen_q        <= 1'b0;
         sel_hi_q     <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_wen_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         err_q        <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         wen_q        <= wen_d;
         sel_hi_q     <= sel_hi_d;
         mem_req_q    <= mem_req_d;
         mem_wen_q    <= mem_wen_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         err_q        <= err_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign i_rdata   = i_rdata_q;
   assign i_ack     = i_ack_q;
   assign d_rdata   = d_rdata_q;
   assign d_ack     = d_ack_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
